// File: rtl/clock_enable_controller.sv
// clock_enable_controller: programmable clock-enable tick and 50% divided level with boundary-aligned reconfiguration
module clock_enable_controller #(
    parameter int CNT_WIDTH   = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 cfg_valid,
    input  logic [CNT_WIDTH-1:0] cfg_div,
    output logic                 cfg_ready,
    output logic                 cfg_err,
    output logic                 clk_en_out,
    output logic                 clk_div_out,
    output logic [CNT_WIDTH-1:0] div_active,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n, div_n, pending, pending_n;
    logic                 en_n, dv_n, err_n;
    logic                 xfer, cfg_ok, tick, boundary;

    assign cfg_ready = state != PEND;
    assign xfer      = cfg_valid && cfg_ready;
    assign cfg_ok    = xfer && cfg_div != '0;
    assign tick      = cnt == div_active - CNT_WIDTH'(1);
    assign boundary  = tick && clk_div_out;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        div_n     = div_active;
        pending_n = pending;
        en_n      = 1'b0;
        dv_n      = 1'b0;
        err_n     = xfer && cfg_div == '0;
        if (state == IDLE) begin
            div_n = cfg_ok ? cfg_div : div_active;
            if (run) begin
                state_n = RUN;
                cnt_n   = '0;
            end
        end else begin
            cnt_n = tick ? '0 : cnt + CNT_WIDTH'(1);
            en_n  = tick;
            dv_n  = tick ? ~clk_div_out : clk_div_out;
            if (state == RUN && cfg_ok) begin
                pending_n = cfg_div;
                state_n   = PEND;
            end
            // a period ends only on the falling tick, keeping the divided level glitch-free
            if (boundary) begin
                if (state == PEND) begin
                    div_n   = pending;
                    state_n = RUN;
                end
                if (!run) begin
                    state_n = IDLE;
                    div_n   = cfg_ok ? cfg_div : div_n;
                end
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pending     <= '0;
            div_active  <= CNT_WIDTH'(DEFAULT_DIV);
            clk_en_out  <= 1'b0;
            clk_div_out <= 1'b0;
            cfg_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pending     <= pending_n;
            div_active  <= div_n;
            clk_en_out  <= en_n;
            clk_div_out <= dv_n;
            cfg_err     <= err_n;
            busy        <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_clock_enable_controller.sv
// tb_clock_enable_controller: scoreboard bench with a period-position reference model
module tb_clock_enable_controller;
    localparam int W = 16;
    localparam int DEF = 2;

    logic         clock_in = 1'b0;
    logic         reset = 1'b1, run = 1'b0, cfg_valid = 1'b0;
    logic [W-1:0] cfg_div = '0;
    logic         cfg_ready, cfg_err, clk_en_out, clk_div_out, busy;
    logic [W-1:0] div_active;

    clock_enable_controller #(.CNT_WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clock_in(clock_in), .reset(reset), .run(run), .cfg_valid(cfg_valid),
        .cfg_div(cfg_div), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .clk_en_out(clk_en_out), .clk_div_out(clk_div_out),
        .div_active(div_active), .busy(busy)
    );

    always #5 clock_in = ~clock_in;

    typedef struct packed {
        logic         en, dv, err, busy, ready;
        logic [W-1:0] div;
    } exp_t;

    exp_t q[$];
    exp_t mon_e, got;
    int   checks = 0, errors = 0, cyc = 0;

    // model: k counts edges since the current 2N-cycle period began
    bit m_running = 0, m_pendv = 0;
    int m_n = DEF, m_pv = 0, m_k = 0;

    task automatic step(input bit r, input bit rn, input bit v, input int d);
        exp_t e;
        bit xfer, ok;
        @(negedge clock_in);
        reset = r; run = rn; cfg_valid = v; cfg_div = d[W-1:0];
        xfer = v && !m_pendv;
        ok = xfer && d != 0;
        e = '0;
        if (r) begin
            m_running = 0; m_pendv = 0; m_n = DEF; m_k = 0;
        end else begin
            e.err = xfer && d == 0;
            if (!m_running) begin
                if (ok) m_n = d;
                if (rn) begin m_running = 1; m_k = 0; end
            end else begin
                m_k++;
                e.en = (m_k % m_n) == 0;
                e.dv = ((m_k / m_n) % 2) == 1;
                if (m_k == 2 * m_n) begin
                    m_k = 0;
                    if (m_pendv) begin m_n = m_pv; m_pendv = 0; end
                    if (!rn) begin
                        m_running = 0;
                        if (ok) m_n = d;
                    end else if (ok) begin
                        m_pendv = 1; m_pv = d;
                    end
                end else if (ok) begin
                    m_pendv = 1; m_pv = d;
                end
            end
        end
        e.busy = m_running;
        e.ready = !m_pendv;
        e.div = m_n[W-1:0];
        q.push_back(e);
    endtask

    task automatic idle(input int n, input bit rn);
        for (int i = 0; i < n; i++) step(0, rn, 0, 0);
    endtask

    always @(posedge clock_in) begin
        #1;
        cyc++;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            got = '{clk_en_out, clk_div_out, cfg_err, busy, cfg_ready, div_active};
            checks++;
            if (got !== mon_e) begin
                errors++;
                $display("FAIL outputs cycle %0d: got en=%b dv=%b err=%b busy=%b rdy=%b div=%0d exp en=%b dv=%b err=%b busy=%b rdy=%b div=%0d",
                         cyc, got.en, got.dv, got.err, got.busy, got.ready, got.div,
                         mon_e.en, mon_e.dv, mon_e.err, mon_e.busy, mon_e.ready, mon_e.div);
            end
        end
    end

    initial begin
        bit rr;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        idle(2, 0);
        idle(13, 1);
        step(0, 1, 1, 5);
        idle(26, 1);
        idle(25, 0);
        step(0, 0, 1, 2);
        step(0, 0, 1, 0);
        idle(3, 0);
        step(0, 0, 1, 3);
        idle(4, 1);
        idle(12, 0);
        step(0, 0, 1, 1);
        idle(7, 1);
        step(0, 1, 1, 4);
        idle(20, 1);
        step(0, 1, 1, 6);
        idle(2, 1);
        step(1, 1, 0, 0);
        idle(6, 0);
        idle(10, 1);
        rr = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) rr = !rr;
            step($urandom_range(0, 299) == 0, rr, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 6)));
        end
        idle(2, 0);
        repeat (2) @(posedge clock_in);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
